// File: rtl/xs3_bcd_seq_ctrl_pkg.sv
// Shared types and constants for the Excess-3 to BCD sequencing controller.
package xs3_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } xs3_state_t;

   localparam int         XS3_DIGIT_W = 4;
   localparam logic [3:0] XS3_OFFSET  = 4'd3;
   localparam logic [3:0] XS3_MIN     = 4'h3;
   localparam logic [3:0] XS3_MAX     = 4'hC;

endpackage

// File: rtl/xs3_bcd_seq_ctrl_digit_dec.sv
// Single Excess-3 digit decoder; out-of-range codes decode to zero and raise invalid.
module xs3_digit_dec
   import xs3_pkg::*;
(
   input  logic [3:0] code,
   output logic [3:0] bcd,
   output logic       invalid
);

   always_comb begin
      invalid = (code < XS3_MIN) || (code > XS3_MAX);
      bcd     = invalid ? 4'h0 : (code - XS3_OFFSET);
   end

endmodule

// File: rtl/xs3_bcd_seq_ctrl.sv
// Multi-digit Excess-3 to BCD controller sharing one digit decoder, LSB digit first.
// Optional per-digit error reporting is enabled by defining XS3_ERR_DETECT_EN.
module xs3_bcd_seq_ctrl
   import xs3_pkg::*;
#(
   parameter int NDIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NDIGITS-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NDIGITS-1:0] out_data,
   output logic                 out_err,
   output logic [NDIGITS-1:0]   err_mask
);

   localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int W     = XS3_DIGIT_W * NDIGITS;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS - 1);

   xs3_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]   cap_q, cap_d;
   logic [W-1:0]   data_q, data_d;
   logic [3:0]     dig_code;
   logic [3:0]     dig_bcd;
   logic           dig_inv;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = data_q;

   // Select the digit addressed by the counter for the shared decoder.
   always_comb begin
      dig_code = 4'h0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (cnt_q == CNT_W'(i)) dig_code = cap_q[XS3_DIGIT_W*i +: XS3_DIGIT_W];
      end
   end

   xs3_digit_dec u_dec (
      .code    (dig_code),
      .bcd     (dig_bcd),
      .invalid (dig_inv)
   );

`ifdef XS3_ERR_DETECT_EN
   logic [NDIGITS-1:0] err_q, err_d;
   assign err_mask = err_q;
   assign out_err  = |err_q;
`else
   logic unused_dig_inv;
   assign unused_dig_inv = dig_inv;
   assign err_mask = '0;
   assign out_err  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      data_d  = data_q;
`ifdef XS3_ERR_DETECT_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               cap_d   = in_data;
               data_d  = '0;
               cnt_d   = '0;
`ifdef XS3_ERR_DETECT_EN
               err_d   = '0;
`endif
               state_d = CONV;
            end
         end
         CONV: begin
            for (int i = 0; i < NDIGITS; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  data_d[XS3_DIGIT_W*i +: XS3_DIGIT_W] = dig_bcd;
`ifdef XS3_ERR_DETECT_EN
                  err_d[i] = dig_inv;
`endif
               end
            end
            if (cnt_q == LAST) state_d = DONE;
            else               cnt_d   = cnt_q + 1'b1;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
         data_q  <= '0;
`ifdef XS3_ERR_DETECT_EN
         err_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         data_q  <= data_d;
`ifdef XS3_ERR_DETECT_EN
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_xs3_bcd_seq_ctrl.sv
// Directed self-checking bench for xs3_bcd_seq_ctrl (NDIGITS=4 and NDIGITS=1 instances).
module tb_xs3_bcd_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, out_valid, out_err;
   logic [15:0] out_data;
   logic [3:0]  err_mask;

   logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic [3:0]  in_data1 = '0;
   logic        in_ready1, out_valid1, out_err1;
   logic [3:0]  out_data1;
   logic [0:0]  err_mask1;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   xs3_bcd_seq_ctrl #(.NDIGITS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .err_mask(err_mask)
   );

   xs3_bcd_seq_ctrl #(.NDIGITS(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_err(out_err1), .err_mask(err_mask1)
   );

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single handshake edge, then count cycles until out_valid.
   task automatic send_word(input logic [15:0] w, output int lat);
      in_data  = w;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         cycle();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      total++; if (out_data !== 16'h0000) $display("[TB] FAIL reset_out_data got %h want 0000", out_data); else passed++;
      total++; if (out_err !== 1'b0) $display("[TB] FAIL reset_out_err got %b want 0", out_err); else passed++;
      total++; if (err_mask !== 4'b0000) $display("[TB] FAIL reset_err_mask got %b want 0000", err_mask); else passed++;
      total++; if (in_ready1 !== 1'b1) $display("[TB] FAIL reset_in_ready1 got %b want 1", in_ready1); else passed++;
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b1;
      send_word(16'hC4A3, lat);
      total++; if (lat !== 4) $display("[TB] FAIL basic_latency got %0d want 4", lat); else passed++;
      total++; if (out_data !== 16'h9170) $display("[TB] FAIL basic_data got %h want 9170", out_data); else passed++;
      total++; if (out_err !== 1'b0) $display("[TB] FAIL basic_err got %b want 0", out_err); else passed++;
      cycle();
      total++; if (in_ready !== 1'b1) $display("[TB] FAIL basic_ready_after got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_valid_after got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_boundary();
      int lat;
      out_ready = 1'b1;
      send_word(16'h3333, lat);
      total++; if (out_data !== 16'h0000) $display("[TB] FAIL bound_3333_data got %h want 0000", out_data); else passed++;
      total++; if (err_mask !== 4'b0000) $display("[TB] FAIL bound_3333_mask got %b want 0000", err_mask); else passed++;
      cycle();
      send_word(16'hCCCC, lat);
      total++; if (out_data !== 16'h9999) $display("[TB] FAIL bound_CCCC_data got %h want 9999", out_data); else passed++;
      total++; if (err_mask !== 4'b0000) $display("[TB] FAIL bound_CCCC_mask got %b want 0000", err_mask); else passed++;
      cycle();
   endtask

   task automatic test_invalid();
      int lat;
      logic [3:0] m1, m2;
      logic       e1, e2;
`ifdef XS3_ERR_DETECT_EN
      m1 = 4'b0100; e1 = 1'b1; m2 = 4'b1111; e2 = 1'b1;
`else
      m1 = 4'b0000; e1 = 1'b0; m2 = 4'b0000; e2 = 1'b0;
`endif
      out_ready = 1'b1;
      send_word(16'h3F36, lat);
      total++; if (out_data !== 16'h0003) $display("[TB] FAIL inv_3F36_data got %h want 0003", out_data); else passed++;
      total++; if (err_mask !== m1) $display("[TB] FAIL inv_3F36_mask got %b want %b", err_mask, m1); else passed++;
      total++; if (out_err !== e1) $display("[TB] FAIL inv_3F36_err got %b want %b", out_err, e1); else passed++;
      cycle();
      send_word(16'h2D01, lat);
      total++; if (out_data !== 16'h0000) $display("[TB] FAIL inv_2D01_data got %h want 0000", out_data); else passed++;
      total++; if (err_mask !== m2) $display("[TB] FAIL inv_2D01_mask got %b want %b", err_mask, m2); else passed++;
      total++; if (out_err !== e2) $display("[TB] FAIL inv_2D01_err got %b want %b", out_err, e2); else passed++;
      cycle();
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      send_word(16'h3456, lat);
      total++; if (lat !== 4) $display("[TB] FAIL bp_latency got %0d want 4", lat); else passed++;
      in_data  = 16'hCCCC;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_valid_%0d got %b want 1", i, out_valid); else passed++;
         total++; if (out_data !== 16'h0123) $display("[TB] FAIL bp_data_%0d got %h want 0123", i, out_data); else passed++;
         total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_%0d got %b want 0", i, in_ready); else passed++;
      end
      in_data   = 16'h4444;
      out_ready = 1'b1;
      cycle();
      total++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready got %b want 1", in_ready); else passed++;
      total++; if (out_data !== 16'h0123) $display("[TB] FAIL bp_idle_hold got %h want 0123", out_data); else passed++;
      cycle();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         cycle();
         lat++;
      end
      total++; if (lat !== 4) $display("[TB] FAIL bp_next_latency got %0d want 4", lat); else passed++;
      total++; if (out_data !== 16'h1111) $display("[TB] FAIL bp_next_data got %h want 1111", out_data); else passed++;
      cycle();
   endtask

   task automatic test_mid_reset();
      int lat;
      out_ready = 1'b1;
      in_data   = 16'hC4A3;
      in_valid  = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL mrst_valid got %b want 0", out_valid); else passed++;
      total++; if (out_data !== 16'h0000) $display("[TB] FAIL mrst_data got %h want 0000", out_data); else passed++;
      total++; if (in_ready !== 1'b1) $display("[TB] FAIL mrst_ready got %b want 1", in_ready); else passed++;
      send_word(16'h5678, lat);
      total++; if (lat !== 4) $display("[TB] FAIL mrst_latency got %0d want 4", lat); else passed++;
      total++; if (out_data !== 16'h2345) $display("[TB] FAIL mrst_data2 got %h want 2345", out_data); else passed++;
      cycle();
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      out_ready = 1'b1;
      in_data   = 16'hBA98;
      in_valid  = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         cycle();
         exp_v = ((c % 6) == 5);
         total++; if (out_valid !== exp_v) $display("[TB] FAIL b2b_valid_c%0d got %b want %b", c, out_valid, exp_v); else passed++;
         if (exp_v) begin
            total++; if (out_data !== 16'h8765) $display("[TB] FAIL b2b_data_c%0d got %h want 8765", c, out_data); else passed++;
         end
      end
      in_valid = 1'b0;
      while (!in_ready) cycle();

      out_ready1 = 1'b1;
      in_data1   = 4'h7;
      in_valid1  = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         cycle();
         exp_v = ((c % 3) == 2);
         total++; if (out_valid1 !== exp_v) $display("[TB] FAIL n1_valid_c%0d got %b want %b", c, out_valid1, exp_v); else passed++;
         if (exp_v) begin
            total++; if (out_data1 !== 4'h4) $display("[TB] FAIL n1_data_c%0d got %h want 4", c, out_data1); else passed++;
         end
      end
      in_valid1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_invalid();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
